fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end for the pipelined RISC-V core. It replaces the fixed PC plus instruction-ROM plus single IF_ID register path.
- It generates sequential fetch addresses and issues pipelined requests to an instruction memory with variable latency.
- Returned instructions and their PCs are buffered in a DEPTH-entry queue, drained by the decode stage under a valid/ready handshake.
- Branch or jump redirects flush the queue and discard any responses still in flight.

Parameters:
- XLEN, 32, address/data width in bits.
- DEPTH, 4, queue entries; also the maximum number of outstanding requests. Power of two, at least 2.
- RESET_PC, 0, fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  branch/jump taken; flush and restart.
- redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored and forced to 0.
- imem_req_valid  out  1  request present.
- imem_req_addr  out  XLEN  word-aligned request address.
- imem_req_ready  in  1  memory accepts request.
- imem_resp_valid  in  1  in-order response present. Always accepted; there is no response ready.
- imem_resp_inst  in  XLEN  returned instruction.
- deq_valid  out  1  queue head valid.
- deq_ready  in  1  decode accepts head. Driven by hazard unit as !IF_ID lock.
- deq_inst  out  XLEN  head instruction; 32'h00000013 (NOP) when deq_valid=0.
- deq_pc  out  XLEN  head PC; 0 when deq_valid=0.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - fetch_pc=RESET_PC; count=0; inflight=0; discard=0.
  - imem_req_valid=0, deq_valid=0, deq_inst=NOP, deq_pc=0.
  - No request is issued in the first cycle after reset deasserts, because outputs are registered.
- Credit rule: imem_req_valid=1 iff count+inflight < DEPTH and no redirect occurs this cycle. This makes overflow impossible.
- Request issue: imem_req_addr=fetch_pc. When imem_req_valid&&imem_req_ready, inflight++ and fetch_pc += 4, wrapping modulo 2^XLEN (0xFFFFFFFC -> 0).
- Response handling:
  - If discard>0, the instruction is dropped, then discard-- and inflight--.
  - Otherwise the instruction is enqueued with its PC (PC FIFO written at request time, popped at response time), count++, inflight--.
  - Responses are strictly in order; latency is arbitrary, 1 cycle or more.
- Dequeue: when deq_valid&&deq_ready, pop the head and count--. Enqueue and dequeue in the same cycle leave count unchanged, including when count==DEPTH-1 or count==DEPTH.
- Latency: response to deq_valid is 1 cycle, registered through the queue.
- Redirect (highest priority):
  - Next cycle: count=0; fetch_pc=redirect_pc.
  - discard = inflight, plus any request accepted this cycle, minus any response arriving this cycle.
  - No new request is issued in the redirect cycle.
  - Any dequeue handshake in that cycle counts as completed.
  - A response arriving in the redirect cycle is dropped.
  - Back-to-back redirects are legal; the last one wins, and discard accumulates correctly.
- Empty: deq_valid=0. Full (count==DEPTH): no requests issued.
- Internal state: ring of DEPTH entries with log2(DEPTH)-bit pointers that wrap naturally. count and inflight are log2(DEPTH)+1 bits wide.
- Assertion: a response with inflight==0 is illegal.

Optional Feature:
- FETCH_QUEUE_BYPASS_EN.
  - Defined: when count==0 and a non-discarded response arrives, deq_valid/deq_inst/deq_pc present it combinationally in the same cycle. If deq_ready=1 it is consumed without being written. This gives zero-cycle response-to-decode latency.
  - Undefined: always registered, with 1-cycle latency.
  - Redirect suppresses bypass in both modes.

Decomposition:
- Shared package core_pkg:
  - XLEN default.
  - NOP_INST=32'h00000013.
  - INST_BYTES=4.
  - RESET_PC default.
  - The "PC plus instruction" entry struct/width constant.
- Sub-module fq_ring: generic DEPTH x WIDTH circular buffer with push/pop/flush and count output. It is instantiated twice: once for instruction plus PC entries, once for the pending-PC FIFO.

Test Plan:
- Reset mid-stream: assert reset while inflight=2 and count=3 -> all outputs at reset values immediately; after release, first request addr=RESET_PC on cycle 2.
- Streaming: DEPTH=4, memory latency 1, deq_ready=1 -> deq_pc sequence 0x0,0x4,0x8,… one per cycle after a 3-cycle ramp, instructions matching the ROM image.
- Backpressure: deq_ready=0 -> exactly 4 requests issued, imem_req_valid drops, count=4. Then deq_ready=1 for 1 cycle -> exactly one new request.
- Redirect with in-flight: latency 3, two outstanding, redirect_pc=0x103 -> both late responses dropped; next deq_pc=0x100; no stale instruction ever has deq_valid=1.
- Wrap: RESET_PC=0xFFFFFFF8 -> deq_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Bypass (FETCH_QUEUE_BYPASS_EN): empty queue, response arrives with deq_ready=1 -> deq_valid in the same cycle, count stays 0. Without the macro -> deq_valid one cycle later.

Source files
------------

// File: rtl/core_pkg.sv
// Shared constants for the core fetch path: word size, NOP encoding, reset PC and queue entry layout.
package core_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam int          INST_BYTES       = 4;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Queue entry: PC in the upper half, instruction in the lower half.
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] inst;
  } fq_entry_t;

  localparam int FQ_ENTRY_W = $bits(fq_entry_t);

  function automatic int entry_width(input int xlen);
    return 2 * xlen;
  endfunction

endpackage

// File: rtl/fq_ring.sv
// Generic DEPTH x WIDTH circular buffer with push, pop, flush and occupancy count.
module fq_ring #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         head_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;

  // Storage carries no reset; only the pointers define which slots are live.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: credit-limited sequential fetch, in-order response queue, redirect flush.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_queue
  import core_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_inst,
  output logic            deq_valid,
  input  logic            deq_ready,
  output logic [XLEN-1:0] deq_inst,
  output logic [XLEN-1:0] deq_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = entry_width(XLEN);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic            armed_q;
  logic [CW-1:0]   count, inflight;
  logic [CW:0]     credits_used;
  logic [XLEN-1:0] pend_pc;
  logic [EW-1:0]   head_entry;
  logic            req_fire, resp_keep, bypass, enq, deq_fire, pop;

  // Every accepted request holds one credit until its slot in the queue is freed.
  assign credits_used   = {1'b0, count} + {1'b0, inflight};
  assign imem_req_valid = armed_q && !redirect_valid && (credits_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_keep      = imem_resp_valid && (discard_q == '0) && !redirect_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = resp_keep && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    deq_valid = 1'b0;
    deq_inst  = XLEN'(NOP_INST);
    deq_pc    = '0;
    if (bypass) begin
      deq_valid = 1'b1;
      deq_inst  = imem_resp_inst;
      deq_pc    = pend_pc;
    end else if (count != '0) begin
      deq_valid = 1'b1;
      deq_inst  = head_entry[XLEN-1:0];
      deq_pc    = head_entry[EW-1:XLEN];
    end
  end

  assign deq_fire = deq_valid && deq_ready;
  assign pop      = deq_fire && !bypass;
  assign enq      = resp_keep && !(bypass && deq_ready);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      discard_d  = inflight + CW'(req_fire) - CW'(imem_resp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
      if (imem_resp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end
  end

  // armed_q holds off the first request for one cycle after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
      armed_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      armed_q    <= 1'b1;
    end
  end

  fq_ring #(.DEPTH(DEPTH), .WIDTH(EW)) u_data_ring (
    .clk         (clk),
    .reset       (reset),
    .push_i      (enq),
    .push_data_i ({pend_pc, imem_resp_inst}),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .head_data_o (head_entry),
    .count_o     (count)
  );

  // Pending-PC FIFO is never flushed: discarded responses still retire their PC, so its count is inflight.
  fq_ring #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_pc_ring (
    .clk         (clk),
    .reset       (reset),
    .push_i      (req_fire),
    .push_data_i (fetch_pc_q),
    .pop_i       (imem_resp_valid),
    .flush_i     (1'b0),
    .head_data_o (pend_pc),
    .count_o     (inflight)
  );

  a_resp_has_request: assert property (@(posedge clk) disable iff (reset)
    imem_resp_valid |-> (inflight != '0));

endmodule
